// File: rtl/riscv_lsu.sv
// Load/store unit: one outstanding data-memory access at a time on a grant/valid bus,
// with byte-lane alignment for stores and sign/zero extension of load data into the GPR file.
module riscv_lsu #(
   parameter  int XLEN = 32,
   localparam int RW   = $clog2(XLEN),
   localparam int BW   = XLEN / 8
) (
   input  logic            clk_i,
   input  logic            arstn_i,
   input  logic            req_i,
   input  logic            we_i,
   input  logic [1:0]      size_i,
   input  logic            unsigned_i,
   input  logic [XLEN-1:0] addr_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [RW-1:0]   rd_i,
   output logic            stall_o,
   output logic            misalign_o,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [BW-1:0]   mem_be_o,
   output logic [XLEN-1:0] mem_addr_o,
   output logic [XLEN-1:0] mem_wdata_o,
   input  logic            mem_gnt_i,
   input  logic            mem_rvalid_i,
   input  logic [XLEN-1:0] mem_rdata_i,
   output logic            gpr_we_o,
   output logic [RW-1:0]   gpr_wa_o,
   output logic [XLEN-1:0] gpr_wd_o
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_e;

   state_e            state_q, state_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [RW-1:0]     rd_q, rd_d;
   logic [1:0]        off_q, off_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [BW-1:0]     mem_be_q, mem_be_d;
   logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
   logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
   logic              gpr_we_q, gpr_we_d;
   logic [RW-1:0]     gpr_wa_q, gpr_wa_d;
   logic [XLEN-1:0]   gpr_wd_q, gpr_wd_d;

   logic              legal;
   logic              idle;
   logic [XLEN-1:0]   shifted;
   logic [XLEN-1:0]   load_data;

   always_comb begin
      legal = 1'b0;
      case (size_i)
         2'b00:   legal = 1'b1;
         2'b01:   legal = ~addr_i[0];
         2'b10:   legal = (addr_i[1:0] == 2'b00);
         default: legal = 1'b0;
      endcase
      idle       = (state_q == S_IDLE);
      misalign_o = idle & req_i & ~legal;
      stall_o    = ~idle | (req_i & legal);
   end

   // Returned word is shifted down to the accessed lane, then extended from its top bit.
   always_comb begin
      shifted   = mem_rdata_i >> {off_q, 3'b000};
      load_data = shifted;
      case (size_q)
         2'b00:   load_data = {{(XLEN-8){~uns_q & shifted[7]}}, shifted[7:0]};
         2'b01:   load_data = {{(XLEN-16){~uns_q & shifted[15]}}, shifted[15:0]};
         default: load_data = shifted;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      size_d      = size_q;
      uns_d       = uns_q;
      rd_d        = rd_q;
      off_d       = off_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_be_d    = mem_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      gpr_we_d    = 1'b0;
      gpr_wa_d    = gpr_wa_q;
      gpr_wd_d    = gpr_wd_q;
      case (state_q)
         S_IDLE: begin
            if (req_i && legal) begin
               we_d       = we_i;
               size_d     = size_i;
               uns_d      = unsigned_i;
               rd_d       = rd_i;
               off_d      = addr_i[1:0];
               mem_req_d  = 1'b1;
               mem_we_d   = we_i;
               mem_addr_d = {addr_i[XLEN-1:2], 2'b00};
               case (size_i)
                  2'b00: begin
                     mem_be_d    = BW'(1) << addr_i[1:0];
                     mem_wdata_d = {(XLEN/8){wdata_i[7:0]}};
                  end
                  2'b01: begin
                     mem_be_d    = BW'(3) << addr_i[1:0];
                     mem_wdata_d = {(XLEN/16){wdata_i[15:0]}};
                  end
                  default: begin
                     mem_be_d    = '1;
                     mem_wdata_d = wdata_i;
                  end
               endcase
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (mem_gnt_i) begin
               mem_req_d = 1'b0;
               state_d   = we_q ? S_IDLE : S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_rvalid_i) begin
               gpr_we_d = (rd_q != '0);
               gpr_wa_d = rd_q;
               gpr_wd_d = load_data;
               state_d  = S_WB;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_q     <= S_IDLE;
         we_q        <= 1'b0;
         size_q      <= 2'b00;
         uns_q       <= 1'b0;
         rd_q        <= '0;
         off_q       <= 2'b00;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         gpr_we_q    <= 1'b0;
         gpr_wa_q    <= '0;
         gpr_wd_q    <= '0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         rd_q        <= rd_d;
         off_q       <= off_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         gpr_we_q    <= gpr_we_d;
         gpr_wa_q    <= gpr_wa_d;
         gpr_wd_q    <= gpr_wd_d;
      end
   end

   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_be_o    = mem_be_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign gpr_we_o    = gpr_we_q;
   assign gpr_wa_o    = gpr_wa_q;
   assign gpr_wd_o    = gpr_wd_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Scoreboard bench for riscv_lsu: directed test-plan cases, then randomized traffic
// against a random-latency bus responder, checked by an independent monitor.
module tb_riscv_lsu;

   logic        clk_i = 1'b0;
   logic        arstn_i;
   logic        req_i, we_i, unsigned_i;
   logic [1:0]  size_i;
   logic [31:0] addr_i, wdata_i;
   logic [4:0]  rd_i;
   logic        stall_o, misalign_o, mem_req_o, mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic        mem_gnt_i, mem_rvalid_i;
   logic        gpr_we_o;
   logic [4:0]  gpr_wa_o;
   logic [31:0] gpr_wd_o;

   logic        auto_bus = 1'b0;
   logic        dir_gnt = 1'b0, dir_rvalid = 1'b0;
   logic [31:0] dir_rdata = 32'h0;
   logic        resp_gnt = 1'b0, resp_rvalid = 1'b0;
   logic [31:0] resp_rdata = 32'h0;

   int vectors = 0;
   int miscompares = 0;

   logic [68:0] bus_q[$];
   logic [9:0]  ld_q[$];
   logic [36:0] gpr_q[$];

   assign mem_gnt_i    = auto_bus ? resp_gnt    : dir_gnt;
   assign mem_rvalid_i = auto_bus ? resp_rvalid : dir_rvalid;
   assign mem_rdata_i  = auto_bus ? resp_rdata  : dir_rdata;

   always #5 clk_i = ~clk_i;

   riscv_lsu dut (
      .clk_i(clk_i), .arstn_i(arstn_i), .req_i(req_i), .we_i(we_i), .size_i(size_i),
      .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i), .rd_i(rd_i),
      .stall_o(stall_o), .misalign_o(misalign_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .gpr_we_o(gpr_we_o), .gpr_wa_o(gpr_wa_o), .gpr_wd_o(gpr_wd_o)
   );

   function automatic logic [31:0] refLoad(input logic [31:0] data, input logic [1:0] size,
                                           input logic uns, input logic [1:0] off);
      int unsigned v;
      v = data;
      v = v >> (8 * off);
      if (size == 2'b00) begin
         v = v % 256;
         if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
      end else if (size == 2'b01) begin
         v = v % 65536;
         if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
      end
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [68:0] act, input logic [68:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Pops the outstanding load and predicts the register-file write for the returned word.
   task automatic expectLoad(input logic [31:0] data);
      logic [9:0] e;
      if (ld_q.size() == 0) return;
      e = ld_q.pop_front();
      if (e[9:5] != 5'd0) gpr_q.push_back({e[9:5], refLoad(data, e[4:3], e[2], e[1:0])});
   endtask

   task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
      logic        legal;
      logic [3:0]  be;
      logic [31:0] wd;
      int unsigned off;
      off   = addr % 4;
      legal = (size == 2'b00) || (size == 2'b01 && off % 2 == 0) || (size == 2'b10 && off == 0);
      be    = (size == 2'b00) ? 4'(1 << off) : (size == 2'b01) ? 4'(3 << off) : 4'hF;
      wd    = (size == 2'b00) ? (wdata % 256) * 32'h0101_0101 :
              (size == 2'b01) ? (wdata % 65536) * 32'h0001_0001 : wdata;
      req_i = 1'b1; we_i = we; size_i = size; unsigned_i = uns;
      addr_i = addr; wdata_i = wdata; rd_i = rd;
      #1;
      checkOutput("misalign", {68'd0, misalign_o}, {68'd0, ~legal});
      checkOutput("stall_on_req", {68'd0, stall_o}, {68'd0, legal});
      if (legal) begin
         bus_q.push_back({we, be, addr - off, wd});
         if (!we) ld_q.push_back({rd, size, uns, 2'(off)});
      end
      @(posedge clk_i); #1;
      req_i = 1'b0;
      if (!legal) checkOutput("no_bus_on_illegal", {67'd0, mem_req_o, stall_o}, 69'd0);
   endtask

   task automatic waitIdle();
      int n = 0;
      while (stall_o && n < 60) begin
         @(posedge clk_i); #1;
         n++;
      end
      if (stall_o) begin
         miscompares++;
         $display("[TB] FAIL idle_timeout: stall_o=%0b expected 0", stall_o);
      end
   endtask

   // Bus responder: grants after a random number of request cycles, returns data later.
   initial begin
      int   g_wait = 0, r_wait = 0;
      logic r_pend = 1'b0;
      forever begin
         @(posedge clk_i); #1;
         resp_gnt = 1'b0; resp_rvalid = 1'b0; resp_rdata = $urandom;
         if (auto_bus) begin
            if (r_pend) begin
               if (r_wait == 0) begin
                  resp_rvalid = 1'b1;
                  expectLoad(resp_rdata);
                  r_pend = 1'b0;
               end else r_wait--;
            end else if (mem_req_o) begin
               if (g_wait == 0) begin
                  resp_gnt = 1'b1;
                  if (!mem_we_o) begin
                     r_pend = 1'b1;
                     r_wait = $urandom_range(0, 3);
                  end
                  g_wait = $urandom_range(0, 3);
               end else g_wait--;
            end
         end
      end
   end

   // Monitor: compares accepted bus transactions and register writes against the queues.
   initial begin
      logic        prev_wait = 1'b0;
      logic [68:0] prev_bus = '0;
      logic [68:0] exp;
      logic [36:0] gexp;
      forever begin
         @(negedge clk_i);
         if (prev_wait && mem_req_o)
            checkOutput("bus_stable", {mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}, prev_bus);
         if (mem_req_o && mem_gnt_i) begin
            if (bus_q.size() == 0) begin
               miscompares++;
               $display("[TB] FAIL bus_unexpected: got addr 0x%0h expected no transaction", mem_addr_o);
            end else begin
               exp = bus_q.pop_front();
               if (!exp[68]) exp[31:0] = mem_wdata_o;
               checkOutput("bus_txn", {mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}, exp);
            end
         end
         if (gpr_we_o) begin
            if (gpr_q.size() == 0) begin
               miscompares++;
               $display("[TB] FAIL gpr_unexpected: got wa %0d wd 0x%0h expected no write", gpr_wa_o, gpr_wd_o);
            end else begin
               gexp = gpr_q.pop_front();
               checkOutput("gpr_write", {32'd0, gpr_wa_o, gpr_wd_o}, {32'd0, gexp});
            end
         end
         prev_wait = mem_req_o && !mem_gnt_i;
         prev_bus  = {mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o};
      end
   end

   initial begin
      arstn_i = 1'b0; req_i = 1'b0; we_i = 1'b0; size_i = 2'b00; unsigned_i = 1'b0;
      addr_i = 32'h0; wdata_i = 32'h0; rd_i = 5'd0;
      #22;
      checkOutput("reset_outputs",
                  {mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o[31:0]}, 69'd0);
      checkOutput("reset_gpr", {30'd0, stall_o, misalign_o, gpr_we_o, gpr_wa_o, gpr_wd_o}, 69'd0);
      arstn_i = 1'b1;
      @(posedge clk_i); #1;

      // lw 0x100, rd=5: gnt at N+1, rvalid at N+2, write at N+3
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd5);
      dir_gnt = 1'b1;
      checkOutput("lw_stall_n1", {68'd0, stall_o}, 69'd1);
      @(posedge clk_i); #1;
      dir_gnt = 1'b0; dir_rvalid = 1'b1; dir_rdata = 32'hDEAD_BEEF;
      expectLoad(dir_rdata);
      checkOutput("lw_stall_n2", {68'd0, stall_o}, 69'd1);
      @(posedge clk_i); #1;
      dir_rvalid = 1'b0;
      checkOutput("lw_write_n3", {30'd0, stall_o, gpr_we_o, 2'b00, gpr_wa_o, gpr_wd_o},
                  {30'd0, 1'b1, 1'b1, 2'b00, 5'd5, 32'hDEAD_BEEF});
      @(posedge clk_i); #1;
      checkOutput("lw_stall_n4", {67'd0, stall_o, gpr_we_o}, 69'd0);

      // lb and lbu from 0x103
      for (int u = 0; u < 2; u++) begin
         applyStimulus(1'b0, 2'b00, 1'(u), 32'h103, 32'h0, 5'd9);
         dir_gnt = 1'b1;
         @(posedge clk_i); #1;
         dir_gnt = 1'b0; dir_rvalid = 1'b1; dir_rdata = 32'h80FF_0000;
         expectLoad(dir_rdata);
         @(posedge clk_i); #1;
         dir_rvalid = 1'b0;
         checkOutput("lb_value", {37'd0, gpr_wd_o}, {37'd0, (u == 0) ? 32'hFFFF_FF80 : 32'h0000_0080});
         waitIdle();
      end

      // sh 0x202 with grant delayed three cycles
      applyStimulus(1'b1, 2'b01, 1'b0, 32'h202, 32'h1234_ABCD, 5'd3);
      repeat (3) begin
         @(posedge clk_i); #1;
      end
      dir_gnt = 1'b1;
      @(posedge clk_i); #1;
      dir_gnt = 1'b0;
      checkOutput("sh_idle", {66'd0, stall_o, mem_req_o, gpr_we_o}, 69'd0);

      // illegal requests
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd4);
      applyStimulus(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 5'd4);

      // lw rd=0: bus access, no register write
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 5'd0);
      dir_gnt = 1'b1;
      @(posedge clk_i); #1;
      dir_gnt = 1'b0; dir_rvalid = 1'b1; dir_rdata = 32'h1111_2222;
      expectLoad(dir_rdata);
      @(posedge clk_i); #1;
      dir_rvalid = 1'b0;
      checkOutput("rd0_no_write", {68'd0, gpr_we_o}, 69'd0);
      waitIdle();

      // reset pulsed while waiting for load data; late rvalid must be ignored
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 5'd7);
      dir_gnt = 1'b1;
      @(posedge clk_i); #1;
      dir_gnt = 1'b0;
      #2 arstn_i = 1'b0;
      #1;
      checkOutput("midreset_outputs",
                  {mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}, 69'd0);
      checkOutput("midreset_gpr", {30'd0, stall_o, misalign_o, gpr_we_o, gpr_wa_o, gpr_wd_o}, 69'd0);
      #2 arstn_i = 1'b1;
      ld_q.delete();
      @(posedge clk_i); #1;
      dir_rvalid = 1'b1; dir_rdata = 32'hCAFE_F00D;
      @(posedge clk_i); #1;
      dir_rvalid = 1'b0;
      checkOutput("late_rvalid_ignored", {67'd0, gpr_we_o, stall_o}, 69'd0);

      // randomized traffic
      auto_bus = 1'b1;
      for (int i = 0; i < 200; i++) begin
         int unsigned r;
         logic [1:0]  sz;
         waitIdle();
         r  = $urandom_range(0, 9);
         sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
         applyStimulus(1'($urandom), sz, 1'($urandom), $urandom, $urandom, 5'($urandom));
      end
      waitIdle();
      repeat (4) @(posedge clk_i);
      #1;
      checkOutput("queues_drained", {37'd0, 10'(bus_q.size()), 10'(ld_q.size()), 12'(gpr_q.size())}, 69'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
